// File: rtl/axis_split_dispatcher.sv
// AXI4-Stream 1-to-M packet dispatcher.
// Whole packets go to one enabled port in round-robin order, registered output.
module axis_split_dispatcher #(
   parameter int M_COUNT    = 3,
   parameter int DATA_WIDTH = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [M_COUNT-1:0]            oen,
   input  logic                          s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [M_COUNT-1:0]            m_axis_tvalid,
   output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_COUNT-1:0]            m_axis_tlast,
   input  logic [M_COUNT-1:0]            m_axis_tready
);

   localparam int PW = $clog2(M_COUNT);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                state, state_d;
   logic [PW-1:0]         grant, grant_d;
   logic [PW-1:0]         ptr, ptr_d;
   logic                  out_valid, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data, out_data_d;
   logic                  out_last, out_last_d;

   logic [PW-1:0]         sel;
   logic                  found;
   logic                  in_hs;
   logic                  out_hs;

   // first enabled port after the last one served, wrapping around
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= M_COUNT; k++) begin
         int idx;
         idx = (int'(ptr) + k) % M_COUNT;
         if (!found && oen[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   assign out_hs = out_valid && m_axis_tready[grant];
   assign s_axis_tready = (state == BUSY) &&
                          (!out_valid || m_axis_tready[grant]);
   assign in_hs = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d     = state;
      grant_d     = grant;
      ptr_d       = ptr;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_last_d  = out_last;
      if (out_hs)
         out_valid_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (s_axis_tvalid && found && !out_valid) begin
               state_d = BUSY;
               grant_d = sel;
            end
         end
         BUSY: begin
            if (in_hs) begin
               out_data_d  = s_axis_tdata;
               out_last_d  = s_axis_tlast;
               out_valid_d = 1'b1;
               if (s_axis_tlast) begin
                  state_d = IDLE;
                  ptr_d   = grant;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         ptr       <= PW'(M_COUNT - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_d;
         grant     <= grant_d;
         ptr       <= ptr_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_last  <= out_last_d;
      end
   end

   // data and last are broadcast; each consumer qualifies with its tvalid
   for (genvar i = 0; i < M_COUNT; i++) begin : g_port
      assign m_axis_tvalid[i] = out_valid && (grant == PW'(i));
      assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = out_data;
      assign m_axis_tlast[i] = out_last;
   end

endmodule

// File: tb/tb_axis_split_dispatcher.sv
// Bench for axis_split_dispatcher.
// Random data and ready patterns against a packet-level routing model.
module tb_axis_split_dispatcher;

   localparam int M  = 3;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [M-1:0]    oen = '0;
   logic            s_valid = 1'b0;
   logic [DW-1:0]   s_data = '0;
   logic            s_last = 1'b0;
   logic            s_ready;
   logic [M-1:0]    mt_valid;
   logic [M*DW-1:0] mt_data;
   logic [M-1:0]    mt_last;
   logic [M-1:0]    mt_ready = '1;

   axis_split_dispatcher #(
      .M_COUNT(M),
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .oen(oen),
      .s_axis_tvalid(s_valid),
      .s_axis_tdata(s_data),
      .s_axis_tlast(s_last),
      .s_axis_tready(s_ready),
      .m_axis_tvalid(mt_valid),
      .m_axis_tdata(mt_data),
      .m_axis_tlast(mt_last),
      .m_axis_tready(mt_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ready generation: 0 all ready, 1 port0 pattern 1,0,0, 2 random
   int rdy_mode = 0;
   int cyc = 0;
   always @(posedge clk) begin
      #1;
      cyc++;
      case (rdy_mode)
         1: mt_ready = {2'b11, (cyc % 3) == 0};
         2: mt_ready = M'($urandom);
         default: mt_ready = '1;
      endcase
   end

   // reference model: packet queues per port, round-robin by last port
   typedef logic [64:0] beat_q_t[$];
   beat_q_t        q [M];
   int             hs_cnt [M];
   int             last_port = M - 1;
   int             cur_port = 0;
   bit             in_pkt = 0;
   bit             pend = 0;
   int             pend_p = 0;
   logic [DW-1:0]  pend_d;
   bit   [M-1:0]   stall = '0;
   logic [DW-1:0]  stall_d [M];

   initial for (int p = 0; p < M; p++) hs_cnt[p] = 0;

   always @(negedge clk) begin
      if (rst) begin
         for (int p = 0; p < M; p++) q[p].delete();
         in_pkt    = 0;
         last_port = M - 1;
         pend      = 0;
         stall     = '0;
      end else begin
         chk("onehot", 64'($onehot0(mt_valid)), 64'd1);
         if (pend) begin
            chk("lat_v", 64'(mt_valid[pend_p]), 64'd1);
            chk("lat_d", mt_data[pend_p*DW +: DW], pend_d);
         end
         pend = 0;
         for (int p = 0; p < M; p++) begin
            if (stall[p]) begin
               chk("hold_v", 64'(mt_valid[p]), 64'd1);
               chk("hold_d", mt_data[p*DW +: DW], stall_d[p]);
            end
            stall[p]   = mt_valid[p] && !mt_ready[p];
            stall_d[p] = mt_data[p*DW +: DW];
         end
         if (|(mt_valid & ~mt_ready))
            chk("stall_rdy", 64'(s_ready), 64'd0);
         for (int p = 0; p < M; p++) begin
            if (mt_valid[p] && mt_ready[p]) begin
               hs_cnt[p]++;
               if (q[p].size() == 0) begin
                  chk("spurious", 64'(p), 64'd99);
               end else begin
                  logic [64:0] e;
                  e = q[p].pop_front();
                  chk("beat_d", mt_data[p*DW +: DW], e[63:0]);
                  chk("beat_l", 64'(mt_last[p]), 64'(e[64]));
               end
            end
         end
         if (s_valid && s_ready) begin
            if (!in_pkt) begin
               bit got;
               got = 0;
               for (int k = 1; k <= M; k++) begin
                  int idx;
                  idx = (last_port + k) % M;
                  if (!got && oen[idx]) begin
                     got = 1;
                     cur_port = idx;
                  end
               end
               in_pkt = 1;
            end
            q[cur_port].push_back({s_last, s_data});
            pend   = 1;
            pend_p = cur_port;
            pend_d = s_data;
            if (s_last) begin
               in_pkt    = 0;
               last_port = cur_port;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_acc();
      bit acc;
      int t;
      acc = 0;
      t = 0;
      do begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 200);
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_pkt(input logic [DW-1:0] base, input int n,
                           input int chg_at, input logic [M-1:0] new_oen,
                           input bit rnd);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = rnd ? {$urandom, $urandom} : base + DW'(i);
         s_last  = (i == n - 1);
         wait_acc();
         if (i == chg_at) oen = new_oen;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
   endtask

   int b0, b1, b2;

   task automatic snap();
      b0 = hs_cnt[0];
      b1 = hs_cnt[1];
      b2 = hs_cnt[2];
   endtask

   task automatic chk_cnt(input string tag, input int e0, input int e1,
                          input int e2);
      chk({tag, "_p0"}, 64'(hs_cnt[0] - b0), 64'(e0));
      chk({tag, "_p1"}, 64'(hs_cnt[1] - b1), 64'(e1));
      chk({tag, "_p2"}, 64'(hs_cnt[2] - b2), 64'(e2));
   endtask

   initial begin
      idle(2);
      chk("rst_tvalid", 64'(mt_valid), 64'd0);
      chk("rst_tready", 64'(s_ready), 64'd0);
      rst = 1'b0;
      idle(2);

      // three packets, all ports enabled
      oen = 3'b111;
      snap();
      send_pkt(64'h10, 4, -1, '0, 0);
      idle(3);
      chk_cnt("t1a", 4, 0, 0);
      snap();
      send_pkt(64'h20, 4, -1, '0, 0);
      idle(3);
      chk_cnt("t1b", 0, 4, 0);
      snap();
      send_pkt(64'h30, 4, -1, '0, 0);
      idle(3);
      chk_cnt("t1c", 0, 0, 4);

      // sparse enable
      oen = 3'b101;
      snap();
      for (int i = 0; i < 4; i++) send_pkt(64'h40 + 64'(i), 1, -1, '0, 0);
      idle(3);
      chk_cnt("t2", 2, 0, 2);

      // nothing enabled: input must be held off
      oen = 3'b000;
      s_valid = 1'b1;
      s_data  = 64'h50;
      s_last  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("off_rdy", 64'(s_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      oen = 3'b010;
      snap();
      send_pkt(64'h50, 2, -1, '0, 0);
      idle(3);
      chk_cnt("t3", 0, 2, 0);

      // stalled consumer on port 0
      oen = 3'b001;
      rdy_mode = 1;
      snap();
      send_pkt(64'h60, 8, -1, '0, 0);
      idle(6);
      rdy_mode = 0;
      idle(2);
      chk_cnt("t4", 8, 0, 0);

      // enable change mid-packet
      do_reset();
      oen = 3'b111;
      snap();
      send_pkt(64'h70, 5, 1, 3'b100, 0);
      idle(3);
      chk_cnt("t5a", 5, 0, 0);
      snap();
      send_pkt(64'h80, 3, -1, '0, 0);
      idle(3);
      chk_cnt("t5b", 0, 0, 3);

      // reset in the middle of a packet
      oen = 3'b111;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = 64'h90 + 64'(i);
         s_last  = 1'b0;
         wait_acc();
      end
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tvalid", 64'(mt_valid), 64'd0);
      chk("arst_tready", 64'(s_ready), 64'd0);
      s_valid = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(1);
      snap();
      send_pkt(64'hA0, 3, -1, '0, 0);
      idle(3);
      chk_cnt("t6", 3, 0, 0);

      // random traffic
      rdy_mode = 2;
      for (int n = 0; n < 40; n++) begin
         logic [M-1:0] o;
         do o = M'($urandom); while (o == '0);
         oen = o;
         if ($urandom_range(0, 3) == 0) begin
            logic [M-1:0] o2;
            do o2 = M'($urandom); while (o2 == '0);
            send_pkt('0, $urandom_range(2, 6), 0, o2, 1);
         end else begin
            send_pkt('0, $urandom_range(1, 6), -1, '0, 1);
         end
         idle($urandom_range(0, 2));
      end
      rdy_mode = 0;
      idle(8);
      for (int p = 0; p < M; p++)
         chk("drained", 64'(q[p].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
